// File: rtl/note_quiz_pkg.sv
// Shared types for the note memory-game controller.
// State encoding, note type and score helpers.
package note_quiz_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GEN,
    ST_PLAY_NOTE,
    ST_PLAY_GAP,
    ST_LISTEN,
    ST_PASS,
    ST_OVER
  } state_t;

  localparam int NOTE_COUNT = 12;
  localparam int SCORE_MAX  = 255;

  typedef logic [3:0] note_t;

  typedef struct packed {
    logic new_game;
    logic gen;
    logic pass;
    logic win;
    logic idx_clr;
    logic idx_inc;
    logic cnt_clr;
    logic cnt_inc;
  } ctl_t;

  // LFSR values 12..15 fold back into the 12-note range.
  function automatic note_t fold_note(input note_t n);
    if (n >= note_t'(NOTE_COUNT))
      return note_t'(n - note_t'(NOTE_COUNT));
    return n;
  endfunction

  function automatic logic [7:0] sat_add(
    input logic [7:0] s,
    input logic [3:0] a
  );
    logic [8:0] sum;
    sum = {1'b0, s} + {5'd0, a};
    if (sum > 9'(SCORE_MAX))
      return 8'(SCORE_MAX);
    return sum[7:0];
  endfunction

endpackage

// File: rtl/note_seq_buf.sv
// Note sequence storage for the memory game.
// One synchronous write port, one combinational read port.
module note_seq_buf
  import note_quiz_pkg::*;
#(
  parameter int SEQ_MAX = 8
) (
  input  logic       clk,
  input  logic       we,
  input  logic [3:0] waddr,
  input  note_t      wdata,
  input  logic [3:0] raddr,
  output note_t      rdata
);

  note_t mem [SEQ_MAX];

  // Write the addressed entry; contents need no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SEQ_MAX; i++) begin
      if (we && waddr == 4'(i))
        mem[i] <= wdata;
    end
  end

  // Mux read keeps the address width independent of depth.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < SEQ_MAX; i++) begin
      if (raddr == 4'(i))
        rdata = mem[i];
    end
  end

endmodule

// File: rtl/note_quiz_ctrl.sv
// Memory-game controller: grows a random note sequence,
// plays it back, then checks the player's presses.
module note_quiz_ctrl
  import note_quiz_pkg::*;
#(
  parameter int SEQ_MAX       = 8,
  parameter int NOTE_TICKS    = 4,
  parameter int GAP_TICKS     = 1,
  parameter int TIMEOUT_TICKS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       tick,
  input  logic [3:0] rand_note,
  output logic       enable_rand,
  input  logic       key_valid,
  input  logic [3:0] key_note,
  output logic       play_en,
  output logic [3:0] play_note,
  output logic [3:0] level,
  output logic [7:0] score,
  output logic       busy,
  output logic       round_pass,
  output logic       game_over,
  output logic       won
);

  localparam logic [15:0] NOTE_LAST = 16'(NOTE_TICKS - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_TICKS - 1);
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_TICKS - 1);
  localparam logic [3:0]  LVL_MAX   = 4'(SEQ_MAX);

  state_t      st;
  state_t      nxt;
  ctl_t        ctl;
  logic [3:0]  idx;
  logic [15:0] cnt;
  note_t       rd_note;
  note_t       wr_note;
  logic        idx_last;
  logic        key_hit;

  assign wr_note  = fold_note(rand_note);
  assign idx_last = (idx == level - 4'd1);
  assign key_hit  = (key_note == rd_note);

  note_seq_buf #(
    .SEQ_MAX(SEQ_MAX)
  ) u_buf (
    .clk  (clk),
    .we   (ctl.gen),
    .waddr(level),
    .wdata(wr_note),
    .raddr(idx),
    .rdata(rd_note)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      st <= ST_IDLE;
    else
      st <= nxt;
  end

  // Next state and datapath control strobes.
  always_comb begin
    nxt = st;
    ctl = '0;
    unique case (st)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          ctl.new_game = 1'b1;
          nxt          = ST_GEN;
        end
      end
      ST_GEN: begin
        ctl.gen     = 1'b1;
        ctl.idx_clr = 1'b1;
        ctl.cnt_clr = 1'b1;
        nxt         = ST_PLAY_NOTE;
      end
      ST_PLAY_NOTE: begin
        if (tick) begin
          if (cnt == NOTE_LAST) begin
            ctl.cnt_clr = 1'b1;
            nxt         = ST_PLAY_GAP;
          end else begin
            ctl.cnt_inc = 1'b1;
          end
        end
      end
      ST_PLAY_GAP: begin
        if (tick) begin
          if (cnt == GAP_LAST) begin
            ctl.cnt_clr = 1'b1;
            if (idx_last) begin
              ctl.idx_clr = 1'b1;
              nxt         = ST_LISTEN;
            end else begin
              ctl.idx_inc = 1'b1;
              nxt         = ST_PLAY_NOTE;
            end
          end else begin
            ctl.cnt_inc = 1'b1;
          end
        end
      end
      ST_LISTEN: begin
        // A press wins over a tick in the same cycle.
        if (key_valid) begin
          ctl.cnt_clr = 1'b1;
          if (!key_hit)
            nxt = ST_OVER;
          else if (idx_last)
            nxt = ST_PASS;
          else
            ctl.idx_inc = 1'b1;
        end else if (tick) begin
          if (cnt == TO_LAST)
            nxt = ST_OVER;
          else
            ctl.cnt_inc = 1'b1;
        end
      end
      ST_PASS: begin
        ctl.pass = 1'b1;
        if (level == LVL_MAX) begin
          ctl.win = 1'b1;
          nxt     = ST_OVER;
        end else begin
          nxt = ST_GEN;
        end
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // Level, score, index, tick counter and win flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= '0;
      score <= '0;
      idx   <= '0;
      cnt   <= '0;
      won   <= 1'b0;
    end else begin
      if (ctl.new_game) begin
        level <= '0;
        score <= '0;
        won   <= 1'b0;
      end
      if (ctl.gen)
        level <= level + 4'd1;
      if (ctl.idx_clr || ctl.new_game)
        idx <= '0;
      else if (ctl.idx_inc)
        idx <= idx + 4'd1;
      if (ctl.cnt_clr)
        cnt <= '0;
      else if (ctl.cnt_inc)
        cnt <= cnt + 16'd1;
      if (ctl.pass)
        score <= sat_add(score, level);
      if (ctl.win)
        won <= 1'b1;
    end
  end

  // State-decoded outputs.
  always_comb begin
    enable_rand = 1'b0;
    play_en     = 1'b0;
    play_note   = '0;
    busy        = 1'b0;
    round_pass  = 1'b0;
    game_over   = 1'b0;
    unique case (st)
      ST_GEN: begin
        enable_rand = 1'b1;
        busy        = 1'b1;
      end
      ST_PLAY_NOTE: begin
        play_en   = 1'b1;
        play_note = rd_note;
        busy      = 1'b1;
      end
      ST_PLAY_GAP: busy = 1'b1;
      ST_LISTEN:   busy = 1'b1;
      ST_PASS: begin
        round_pass = 1'b1;
        busy       = 1'b1;
      end
      ST_OVER: game_over = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_note_quiz_ctrl.sv
// Bench for note_quiz_ctrl: directed game scenarios
// followed by random games against a sequence-level model.
module tb_note_quiz_ctrl;

  localparam int SEQ_M = 2;
  localparam int NT    = 2;
  localparam int GT    = 1;
  localparam int TO    = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       tick;
  logic [3:0] rand_note;
  logic       enable_rand;
  logic       key_valid;
  logic [3:0] key_note;
  logic       play_en;
  logic [3:0] play_note;
  logic [3:0] level;
  logic [7:0] score;
  logic       busy;
  logic       round_pass;
  logic       game_over;
  logic       won;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] q_seq[$];
  int m_level;
  int m_score;
  int m_pos;

  note_quiz_ctrl #(
    .SEQ_MAX      (SEQ_M),
    .NOTE_TICKS   (NT),
    .GAP_TICKS    (GT),
    .TIMEOUT_TICKS(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .tick       (tick),
    .rand_note  (rand_note),
    .enable_rand(enable_rand),
    .key_valid  (key_valid),
    .key_note   (key_note),
    .play_en    (play_en),
    .play_note  (play_note),
    .level      (level),
    .score      (score),
    .busy       (busy),
    .round_pass (round_pass),
    .game_over  (game_over),
    .won        (won)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic model_clear();
    q_seq.delete();
    m_level = 0;
    m_score = 0;
    m_pos   = 0;
  endtask

  // From IDLE/OVER: pulse start, land on the GEN cycle.
  task automatic do_start();
    chk("pre_start_en", enable_rand, 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    model_clear();
    chk("start_en", enable_rand, 1);
    chk("start_busy", busy, 1);
    chk("start_score", score, 0);
    chk("start_over", game_over, 0);
    chk("start_won", won, 0);
  endtask

  // From the GEN cycle: append a note, check the whole playback.
  task automatic gen_and_play(input logic [3:0] rn, input bit noise);
    logic [3:0] f;
    rand_note = rn;
    chk("gen_en", enable_rand, 1);
    chk("gen_busy", busy, 1);
    chk("gen_play", play_en, 0);
    chk("gen_note0", play_note, 0);
    chk("gen_level", level, m_level);
    f = (rn >= 4'd12) ? rn - 4'd12 : rn;
    q_seq.push_back(f);
    m_level++;
    cyc();
    rand_note = 4'($urandom_range(0, 15));
    for (int i = 0; i < q_seq.size(); i++) begin
      for (int t = 0; t < NT; t++) begin
        chk("pn_en", play_en, 1);
        chk("pn_note", play_note, q_seq[i]);
        chk("pn_rand", enable_rand, 0);
        chk("pn_level", level, m_level);
        if (noise && $urandom_range(0, 2) == 0) begin
          key_valid = 1'b1;
          key_note  = 4'($urandom_range(0, 15));
        end
        cyc();
        key_valid = 1'b0;
      end
      for (int t = 0; t < GT; t++) begin
        chk("gap_en", play_en, 0);
        chk("gap_note0", play_note, 0);
        chk("gap_busy", busy, 1);
        cyc();
      end
    end
    m_pos = 0;
  endtask

  task automatic idle_listen(input int n, input bit sn);
    for (int i = 0; i < n; i++) begin
      chk("ls_busy", busy, 1);
      chk("ls_over", game_over, 0);
      chk("ls_play", play_en, 0);
      chk("ls_rand", enable_rand, 0);
      if (sn && $urandom_range(0, 1) == 1)
        start = 1'b1;
      cyc();
      start = 1'b0;
    end
  endtask

  task automatic timeout_expect();
    idle_listen(TO, 1'b0);
    chk("to_over", game_over, 1);
    chk("to_won", won, 0);
    chk("to_busy", busy, 0);
    chk("to_score", score, m_score);
    chk("to_level", level, m_level);
  endtask

  task automatic press(input logic [3:0] k, output bit done);
    logic [3:0] want;
    want      = q_seq[m_pos];
    done      = 1'b0;
    key_valid = 1'b1;
    key_note  = k;
    cyc();
    key_valid = 1'b0;
    if (k != want) begin
      chk("wr_over", game_over, 1);
      chk("wr_won", won, 0);
      chk("wr_busy", busy, 0);
      chk("wr_pass", round_pass, 0);
      chk("wr_score", score, m_score);
      done = 1'b1;
    end else if (m_pos == m_level - 1) begin
      chk("ps_pulse", round_pass, 1);
      chk("ps_busy", busy, 1);
      m_score = (m_score + m_level > 255) ? 255 : m_score + m_level;
      m_pos++;
      cyc();
      chk("ps_pulse_end", round_pass, 0);
      chk("ps_score", score, m_score);
      chk("ps_level", level, m_level);
      if (m_level == SEQ_M) begin
        chk("win_over", game_over, 1);
        chk("win_won", won, 1);
        chk("win_busy", busy, 0);
        done = 1'b1;
      end else begin
        chk("next_gen", enable_rand, 1);
      end
    end else begin
      chk("ok_pass", round_pass, 0);
      chk("ok_busy", busy, 1);
      chk("ok_over", game_over, 0);
      m_pos++;
    end
  endtask

  initial begin
    bit done;
    logic [3:0] k;
    reset     = 1'b1;
    start     = 1'b0;
    tick      = 1'b1;
    key_valid = 1'b0;
    key_note  = '0;
    rand_note = '0;
    model_clear();
    cyc();
    chk("rst_rand", enable_rand, 0);
    chk("rst_play", play_en, 0);
    chk("rst_note", play_note, 0);
    chk("rst_level", level, 0);
    chk("rst_score", score, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pass", round_pass, 0);
    chk("rst_over", game_over, 0);
    chk("rst_won", won, 0);
    reset = 1'b0;
    cyc();
    chk("idle_busy", busy, 0);

    // Full win: 5, then 5 9.
    do_start();
    gen_and_play(4'd5, 1'b0);
    press(4'd5, done);
    gen_and_play(4'd9, 1'b0);
    press(4'd5, done);
    press(4'd9, done);
    chk("win_done", done, 1);

    // Restart from OVER; 14 folds to 2; wrong second key.
    do_start();
    gen_and_play(4'd14, 1'b1);
    press(4'd2, done);
    gen_and_play(4'd9, 1'b0);
    press(4'd2, done);
    press(4'd7, done);
    chk("wrong_done", done, 1);

    // Press on the 4th tick survives; silence times out.
    do_start();
    gen_and_play(4'd3, 1'b0);
    idle_listen(TO - 1, 1'b0);
    press(4'd3, done);
    gen_and_play(4'd0, 1'b0);
    timeout_expect();

    // Keys during playback and start during LISTEN ignored.
    do_start();
    gen_and_play(4'd11, 1'b1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("ign_busy", busy, 1);
    chk("ign_rand", enable_rand, 0);
    press(4'd11, done);
    gen_and_play(4'd4, 1'b1);
    press(4'd11, done);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("ign_over", game_over, 0);
    press(4'd4, done);
    chk("ign_done", done, 1);

    // Async reset mid-playback with nonzero score.
    do_start();
    gen_and_play(4'd6, 1'b0);
    press(4'd6, done);
    rand_note = 4'd8;
    cyc();
    chk("ar_play_pre", play_en, 1);
    chk("ar_score_pre", score, 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_play", play_en, 0);
    chk("ar_busy", busy, 0);
    chk("ar_score", score, 0);
    chk("ar_level", level, 0);
    #1 reset = 1'b0;
    cyc();
    chk("ar_idle_busy", busy, 0);
    chk("ar_idle_over", game_over, 0);
    chk("ar_idle_rand", enable_rand, 0);
    model_clear();

    // Random games.
    for (int g = 0; g < 30; g++) begin
      do_start();
      done = 1'b0;
      while (!done) begin
        gen_and_play(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        while (!done && m_pos < m_level) begin
          if ($urandom_range(0, 19) == 0) begin
            timeout_expect();
            done = 1'b1;
          end else begin
            idle_listen(int'($urandom_range(0, TO - 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 9) == 0)
              k = 4'((int'(q_seq[m_pos]) + 1 + int'($urandom_range(0, 10))) % 12);
            else
              k = q_seq[m_pos];
            press(k, done);
          end
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
